vend_dispenser: RTL
===================

// Module: vend_dispenser
// PURPOSE
// Downstream stage of the coin-counting vending FSM. Captures each one-cycle vend
// event (soda_i with change_i = number of nickels owed), queues it, then sequences
// the physical actuators: a timed soda-motor pulse, then one timed ejector pulse per
// nickel. Each ejected nickel is confirmed by an optical sensor; a missing nickel
// raises a jam fault. Vend events can arrive every 2 cycles, so a FIFO absorbs bursts.
// PARAMETERS
// FIFO_DEPTH   4  queued vend requests (power of 2, >=2)
// SODA_PULSE   8  cycles soda_motor is held high per vend (>=1)
// EJECT_ON     4  cycles nickel_eject is held high per nickel (>=1)
// EJECT_GAP    4  low cycles after each eject pulse (>=1)
// PORTS
// clk           in   1  clock
// reset_n       in   1  synchronous, active-low reset
// soda_i        in   1  one-cycle vend event from upstream FSM
// change_i      in   3  nickels owed with this vend (0-7, dispensed literally)
// nickel_sense  in   1  ejector optical sensor, high while a nickel passes
// clear_fault   in   1  one-cycle pulse; clears jam and overflow
// soda_motor    out  1  soda actuator drive
// nickel_eject  out  1  nickel ejector drive
// vend_done     out  1  one-cycle pulse when a transaction completes normally
// busy          out  1  high when state != IDLE or FIFO not empty
// pending       out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// overflow      out  1  sticky: a vend event was dropped (FIFO full)
// jam           out  1  sticky: nickel not sensed; mirrors state JAM
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, state IDLE, counters 0. Reset mid-transaction
//   aborts it immediately; queued requests are discarded.
// - Push: soda_i=1 writes change_i on the next edge. If FIFO full and no pop that cycle,
//   the event is dropped and overflow sets. Push and pop in same cycle both happen.
// - FSM (Moore, outputs decoded from registered state):
//   IDLE      : FIFO non-empty -> pop head into nickels_left, -> VEND.
//   VEND      : soda_motor=1 for SODA_PULSE cycles -> EJ_ON if nickels_left>0 else DONE.
//   EJ_ON     : nickel_eject=1 for EJECT_ON cycles -> EJ_GAP.
//   EJ_GAP    : eject low EJECT_GAP cycles; at end: if no sense seen since EJ_ON entry
//               -> JAM; else nickels_left-=1, -> EJ_ON if still >0 else DONE.
//   DONE      : vend_done=1 for one cycle -> IDLE.
//   JAM       : all actuators low, jam=1; remaining nickels of this vend abandoned;
//               clear_fault -> IDLE. FIFO keeps accepting/holding requests.
// - nickel_sense sampled each cycle of EJ_ON/EJ_GAP into a seen flag, cleared on EJ_ON entry.
// - Latency: soda_i at cycle 0 into empty FIFO/IDLE -> soda_motor high cycles 2..1+SODA_PULSE.
// - clear_fault clears overflow in any state; same-cycle drop keeps overflow set.
// - Phase counter width $clog2(max(SODA_PULSE,EJECT_ON,EJECT_GAP)+1); no wrap.
// STRUCTURE
// - vend_pkg: typedef logic [2:0] change_t; enum disp_state_t {IDLE,VEND,EJ_ON,
//   EJ_GAP,DONE,JAM}.
// - Sub-module vend_req_fifo (sync FIFO of change_t, full/empty/count, push+pop same cycle).
// TESTING (defaults)
// - soda_i,change_i=1 at c0, sense pulse in c11 -> motor c2-9, eject c10-13, vend_done c18.
// - change_i=0 at c0 -> motor c2-9, no eject, vend_done c10, busy low c11.
// - change_i=4, sense every pulse -> 4 eject pulses, 4 high/4 low, then vend_done.
// - change_i=2, no sense -> one eject pulse, jam=1 from c18; clear_fault -> IDLE, jam=0.
// - 6 vend events every 2 cycles -> 1 dropped, overflow=1, 5 vends completed in order.
// - reset_n low during EJ_ON -> next cycle all outputs 0, pending=0, state IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vend dispenser: nickel count per vend and the actuator
// sequencer states.
package vend_pkg;

  typedef logic [2:0] change_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    EJ_ON  = 3'd2,
    EJ_GAP = 3'd3,
    DONE   = 3'd4,
    JAM    = 3'd5
  } disp_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Small synchronous FIFO of pending vend requests; push and pop may occur in
// the same cycle, including when full.
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  change_t                  data_i,
  input  logic                     pop_i,
  output change_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  change_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    count_q;
  logic           wr_en;
  logic           rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  // A pop frees the head slot this cycle, so a full FIFO still accepts a push.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_q <= wr_q + AW'(1);
      end
      if (rd_en) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Queues vend events and sequences the soda motor and nickel ejector, with
// optical confirmation of each nickel and sticky jam/overflow faults.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SODA_PULSE = 8,
  parameter int EJECT_ON   = 4,
  parameter int EJECT_GAP  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          soda_i,
  input  logic [2:0]                    change_i,
  input  logic                          nickel_sense,
  input  logic                          clear_fault,
  output logic                          soda_motor,
  output logic                          nickel_eject,
  output logic                          vend_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow,
  output logic                          jam
);

  localparam int PH_MAX = max3(SODA_PULSE, EJECT_ON, EJECT_GAP);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  disp_state_t                  state_q, state_d;
  logic [PH_W-1:0]              phase_q, phase_d;
  change_t                      left_q, left_d;
  logic                         seen_q, seen_d;
  logic                         overflow_q, overflow_d;
  logic                         seen_any;
  logic                         pop;
  logic                         drop;
  logic                         fifo_full;
  logic                         fifo_empty;
  change_t                      fifo_head;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  vend_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (soda_i),
    .data_i  (change_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign drop       = soda_i & fifo_full & ~pop;
  assign overflow_d = (overflow_q & ~clear_fault) | drop;
  // The final gap cycle's sensor sample still counts toward this nickel.
  assign seen_any   = seen_q | nickel_sense;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    left_d  = left_q;
    seen_d  = seen_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          left_d  = fifo_head;
          phase_d = '0;
          state_d = VEND;
        end
      end
      VEND: begin
        if (phase_q == PH_W'(SODA_PULSE - 1)) begin
          phase_d = '0;
          seen_d  = 1'b0;
          state_d = (left_q != '0) ? EJ_ON : DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      EJ_ON: begin
        seen_d = seen_any;
        if (phase_q == PH_W'(EJECT_ON - 1)) begin
          phase_d = '0;
          state_d = EJ_GAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      EJ_GAP: begin
        seen_d = seen_any;
        if (phase_q == PH_W'(EJECT_GAP - 1)) begin
          phase_d = '0;
          seen_d  = 1'b0;
          if (!seen_any) begin
            state_d = JAM;
          end else begin
            left_d  = left_q - 3'd1;
            state_d = (left_q > 3'd1) ? EJ_ON : DONE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      JAM: begin
        if (clear_fault) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      left_q     <= '0;
      seen_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      left_q     <= left_d;
      seen_q     <= seen_d;
      overflow_q <= overflow_d;
    end
  end

  assign soda_motor   = (state_q == VEND);
  assign nickel_eject = (state_q == EJ_ON);
  assign vend_done    = (state_q == DONE);
  assign jam          = (state_q == JAM);
  assign busy         = (state_q != IDLE) | ~fifo_empty;
  assign pending      = fifo_count;
  assign overflow     = overflow_q;

endmodule
